// File: rtl/riscv_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// riscv_pkg : shared arbiter state encoding and owner identifiers
// Rev 1.0
// ------------------------------------------------------------------
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_DM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb_prio_sel.sv
`default_nettype none
// ------------------------------------------------------------------
// arb_prio_sel : data-first winner select with fetch anti-starvation counter
// Rev 1.0
// ------------------------------------------------------------------
module arb_prio_sel
  import riscv_pkg::*;
#(
  parameter int STARVE_LIM = 2
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic if_req_in,
  input  logic dm_req_in,
  input  logic arb_en_in,
  output logic owner_out
);

  localparam int                c_cnt_w      = 4;
  localparam logic [c_cnt_w-1:0] c_starve_lim = c_cnt_w'(STARVE_LIM);

  logic [c_cnt_w-1:0] r_starve_cnt;
  logic               w_if_due;
  logic               w_owner;

  assign w_if_due  = (r_starve_cnt == c_starve_lim);
  assign w_owner   = (dm_req_in && !(if_req_in && w_if_due)) ? OWNER_DM : OWNER_IF;
  assign owner_out = w_owner;

  // Counter only moves on an actual arbitration decision.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_starve_cnt <= '0;
    end else if (arb_en_in) begin
      if (w_owner == OWNER_IF) begin
        r_starve_cnt <= '0;
      end else if (if_req_in && !w_if_due) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// imem_dmem_arbiter : shares one req/gnt/rvalid memory port between fetch and load/store
// Rev 1.0
// ------------------------------------------------------------------
module imem_dmem_arbiter
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 2
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                if_req_in,
  input  logic [ADDR_W-1:0]   if_addr_in,
  output logic [DATA_W-1:0]   if_rdata_out,
  output logic                if_ack_out,
  input  logic                dm_req_in,
  input  logic                dm_we_in,
  input  logic [ADDR_W-1:0]   dm_addr_in,
  input  logic [DATA_W-1:0]   dm_wdata_in,
  input  logic [DATA_W/8-1:0] dm_mask_in,
  output logic [DATA_W-1:0]   dm_rdata_out,
  output logic                dm_ack_out,
  output logic                mem_req_out,
  output logic                mem_we_out,
  output logic [ADDR_W-1:0]   mem_addr_out,
  output logic [DATA_W-1:0]   mem_wdata_out,
  output logic [DATA_W/8-1:0] mem_mask_out,
  input  logic                mem_gnt_in,
  input  logic                mem_rvalid_in,
  input  logic [DATA_W-1:0]   mem_rdata_in,
  output logic                stall_out,
  output logic                proto_err_out
);

  arb_state_t          r_state;
  logic                r_owner;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W/8-1:0] r_mem_mask;
  logic [DATA_W-1:0]   r_if_rdata;
  logic [DATA_W-1:0]   r_dm_rdata;
  logic                r_if_ack;
  logic                r_dm_ack;
  logic                r_proto_err;
  logic                w_arb_en;
  logic                w_owner;

  assign w_arb_en = (r_state == IDLE) && (if_req_in || dm_req_in);

  arb_prio_sel #(
    .STARVE_LIM (STARVE_LIM)
  ) u_prio_sel (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .if_req_in (if_req_in),
    .dm_req_in (dm_req_in),
    .arb_en_in (w_arb_en),
    .owner_out (w_owner)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= IDLE;
      r_owner     <= OWNER_IF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_mask  <= '0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      // A response is only legal while a command is outstanding.
      if (mem_rvalid_in && (r_state != WAIT)) begin
        r_proto_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (w_arb_en) begin
            r_owner   <= w_owner;
            r_mem_req <= 1'b1;
            if (w_owner == OWNER_DM) begin
              r_mem_we    <= dm_we_in;
              r_mem_addr  <= dm_addr_in;
              r_mem_wdata <= dm_wdata_in;
              r_mem_mask  <= dm_mask_in;
            end else begin
              r_mem_we    <= 1'b0;
              r_mem_addr  <= if_addr_in;
              r_mem_wdata <= '0;
              r_mem_mask  <= '0;
            end
            r_state <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_in) begin
            r_mem_req <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid_in) begin
            if (r_owner == OWNER_DM) begin
              r_dm_ack <= 1'b1;
              if (!r_mem_we) r_dm_rdata <= mem_rdata_in;
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= mem_rdata_in;
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          r_if_ack <= 1'b0;
          r_dm_ack <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_rdata_out  = r_if_rdata;
  assign if_ack_out    = r_if_ack;
  assign dm_rdata_out  = r_dm_rdata;
  assign dm_ack_out    = r_dm_ack;
  assign mem_req_out   = r_mem_req;
  assign mem_we_out    = r_mem_we;
  assign mem_addr_out  = r_mem_addr;
  assign mem_wdata_out = r_mem_wdata;
  assign mem_mask_out  = r_mem_mask;
  assign proto_err_out = r_proto_err;
  assign stall_out     = (if_req_in & ~r_if_ack) | (dm_req_in & ~r_dm_ack);

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_imem_dmem_arbiter : vector table + scoreboard bench with a delay-configurable memory model
// Rev 1.0
// ------------------------------------------------------------------
module tb_imem_dmem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        if_req_in = 1'b0;
  logic [31:0] if_addr_in = '0;
  logic [31:0] if_rdata_out;
  logic        if_ack_out;
  logic        dm_req_in = 1'b0;
  logic        dm_we_in = 1'b0;
  logic [31:0] dm_addr_in = '0;
  logic [31:0] dm_wdata_in = '0;
  logic [3:0]  dm_mask_in = '0;
  logic [31:0] dm_rdata_out;
  logic        dm_ack_out;
  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [3:0]  mem_mask_out;
  logic        mem_gnt_in;
  logic        mem_rvalid_in;
  logic [31:0] mem_rdata_in;
  logic        stall_out;
  logic        proto_err_out;

  imem_dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_rdata_out(if_rdata_out), .if_ack_out(if_ack_out),
    .dm_req_in(dm_req_in), .dm_we_in(dm_we_in), .dm_addr_in(dm_addr_in),
    .dm_wdata_in(dm_wdata_in), .dm_mask_in(dm_mask_in),
    .dm_rdata_out(dm_rdata_out), .dm_ack_out(dm_ack_out),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_addr_out(mem_addr_out),
    .mem_wdata_out(mem_wdata_out), .mem_mask_out(mem_mask_out),
    .mem_gnt_in(mem_gnt_in), .mem_rvalid_in(mem_rvalid_in), .mem_rdata_in(mem_rdata_in),
    .stall_out(stall_out), .proto_err_out(proto_err_out)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'hC0DE_0000) + 32'h11);
  endfunction

  // ---------------- memory model ----------------
  int          gnt_dly = 0;
  int          rv_dly  = 0;
  bit          inject_rv = 0;
  bit          in_req = 0;
  bit          pend = 0;
  bit          stable = 1;
  int          g_cnt = 0;
  int          r_cnt = 0;
  logic [31:0] rsp_data;
  logic        snap_we;
  logic [31:0] snap_addr, snap_wdata;
  logic [3:0]  snap_mask;
  logic        cap_we = 0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [3:0]  cap_mask = '0;

  initial begin
    mem_gnt_in = 0; mem_rvalid_in = 0; mem_rdata_in = '0;
    forever begin
      @(negedge clk_in);
      mem_gnt_in = 0; mem_rvalid_in = 0;
      if (!rst_in) begin
        in_req = 0; pend = 0; inject_rv = 0;
      end else if (inject_rv) begin
        mem_rvalid_in = 1; mem_rdata_in = 32'h5555_AAAA; inject_rv = 0;
      end else if (pend) begin
        if (r_cnt == 0) begin
          mem_rvalid_in = 1; mem_rdata_in = rsp_data; pend = 0;
        end else r_cnt--;
      end else if (mem_req_out === 1'b1) begin
        if (!in_req) begin
          in_req = 1; g_cnt = gnt_dly; stable = 1;
          snap_we = mem_we_out; snap_addr = mem_addr_out;
          snap_wdata = mem_wdata_out; snap_mask = mem_mask_out;
        end else if ({mem_we_out, mem_addr_out, mem_wdata_out, mem_mask_out} !==
                     {snap_we, snap_addr, snap_wdata, snap_mask}) stable = 0;
        if (g_cnt == 0) begin
          mem_gnt_in = 1; in_req = 0; pend = 1; r_cnt = rv_dly;
          rsp_data = mem_we_out ? 32'h0BAD_0BAD : mem_fn(mem_addr_out);
          cap_we = mem_we_out; cap_addr = mem_addr_out;
          cap_wdata = mem_wdata_out; cap_mask = mem_mask_out;
          chk("cmd_stable", stable, 1);
        end else g_cnt--;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct { bit we; logic [31:0] data; } sb_t;
  sb_t         if_q[$];
  sb_t         dm_q[$];
  bit          order_q[$];
  logic [31:0] last_if = '0;
  logic [31:0] last_dm = '0;

  initial begin
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        if (if_ack_out === 1'b1) begin
          order_q.push_back(1'b0);
          if (if_q.size() == 0) chk("if_unexpected_ack", 1, 0);
          else begin
            sb_t e;
            e = if_q.pop_front();
            last_if = e.data;
            chk("if_rdata", if_rdata_out, last_if);
          end
          chk("dm_rdata_hold", dm_rdata_out, last_dm);
        end
        if (dm_ack_out === 1'b1) begin
          order_q.push_back(1'b1);
          if (dm_q.size() == 0) chk("dm_unexpected_ack", 1, 0);
          else begin
            sb_t e;
            e = dm_q.pop_front();
            if (!e.we) last_dm = e.data;
            chk("dm_rdata", dm_rdata_out, last_dm);
          end
          chk("if_rdata_hold", if_rdata_out, last_if);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit dm, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask, input int exp_lat);
    sb_t e;
    int  cyc;
    bit  stall_ok;
    bit  done;
    e.we = dm & we;
    e.data = mem_fn(addr);
    if (dm) begin
      dm_we_in = we; dm_addr_in = addr; dm_wdata_in = wdata; dm_mask_in = mask;
      dm_q.push_back(e); dm_req_in = 1;
    end else begin
      if_addr_in = addr; if_q.push_back(e); if_req_in = 1;
    end
    cyc = 0; stall_ok = 1; done = 0;
    while (!done && cyc < 60) begin
      @(posedge clk_in); #1;
      cyc++;
      if (dm ? dm_ack_out : if_ack_out) done = 1;
      else if (!stall_out) stall_ok = 0;
    end
    if (!done) chk("ack_timeout", 0, 1);
    else if (exp_lat >= 0) begin
      chk("latency", cyc, exp_lat);
      chk("stall_before_ack", stall_ok, 1);
      chk("stall_at_ack", stall_out, 0);
      chk("cmd_we", cap_we, e.we);
      chk("cmd_addr", cap_addr, addr);
      if (dm && we) begin
        chk("cmd_wdata", cap_wdata, wdata);
        chk("cmd_mask", cap_mask, mask);
      end
    end
    if (dm) dm_req_in = 0; else if_req_in = 0;
  endtask

  task automatic do_reset();
    logic any;
    @(negedge clk_in); #2;
    rst_in = 0; if_req_in = 0; dm_req_in = 0;
    #1;
    any = |{if_rdata_out, if_ack_out, dm_rdata_out, dm_ack_out, mem_req_out, mem_we_out,
            mem_addr_out, mem_wdata_out, mem_mask_out, proto_err_out, stall_out};
    chk("reset_outputs_zero", any, 0);
    @(negedge clk_in); #2;
    rst_in = 1;
    last_if = '0; last_dm = '0;
    if_q.delete(); dm_q.delete();
  endtask

  typedef struct {
    bit dm; bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask;
    int g; int r; int lat;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         4'h0, 0, 0, 3};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0204, 32'h1234_5678, 4'h3, 3, 0, 6};
    vecs[2] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 0, 3};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,         4'h0, 1, 2, 6};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,         4'h0, 0, 3, 6};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0088, 32'h0000_A5A5, 4'hF, 2, 1, 6};
    vecs[6] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 0, 0, 3};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_0008, 32'h0,         4'h0, 2, 0, 5};

    do_reset();
    @(posedge clk_in); #1;

    for (int i = 0; i < 8; i++) begin
      gnt_dly = vecs[i].g; rv_dly = vecs[i].r;
      issue(vecs[i].dm, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].lat);
      @(posedge clk_in); #1;
    end
    gnt_dly = 0; rv_dly = 0;

    // stray response in IDLE
    inject_rv = 1;
    repeat (3) @(posedge clk_in);
    #1;
    chk("proto_err_set", proto_err_out, 1);
    chk("no_ack_on_stray", {if_ack_out, dm_ack_out}, 2'b00);
    issue(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 3);
    chk("proto_err_sticky", proto_err_out, 1);
    @(posedge clk_in); #1;

    // reset while waiting for a response
    rv_dly = 5;
    if_addr_in = 32'h20; if_req_in = 1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    chk("in_wait_req_low", mem_req_out, 0);
    do_reset();
    rv_dly = 0;
    @(posedge clk_in); #1;
    issue(1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 3);
    @(posedge clk_in); #1;

    // starvation: both ports requesting continuously
    do_reset();
    @(posedge clk_in); #1;
    order_q.delete();
    fork
      begin
        for (int a = 0; a < 2; a++) issue(1'b0, 1'b0, 32'h80 + 32'(4 * a), 32'h0, 4'h0, -1);
      end
      begin
        for (int b = 0; b < 4; b++) issue(1'b1, 1'b0, 32'h400 + 32'(4 * b), 32'h0, 4'h0, -1);
      end
    join
    @(negedge clk_in);
    chk("starve_count", order_q.size(), 6);
    if (order_q.size() == 6) begin
      bit exp_order[6];
      exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 6; k++) chk($sformatf("starve_order[%0d]", k), order_q[k], exp_order[k]);
    end
    @(posedge clk_in); #1;

    // request held through the fetch ack cycle with a data request waiting
    order_q.delete();
    fork
      begin
        issue(1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, -1);
        issue(1'b0, 1'b0, 32'h0000_0004, 32'h0, 4'h0, -1);
      end
      begin
        @(posedge clk_in); #1;
        issue(1'b1, 1'b0, 32'h0000_0600, 32'h0, 4'h0, -1);
      end
    join
    @(negedge clk_in);
    chk("ackcyc_count", order_q.size(), 3);
    if (order_q.size() == 3) begin
      chk("ackcyc_first_if", order_q[0], 1'b0);
      chk("ackcyc_dm_wins", order_q[1], 1'b1);
      chk("ackcyc_if_next", order_q[2], 1'b0);
    end
    chk("sb_if_empty", if_q.size(), 0);
    chk("sb_dm_empty", dm_q.size(), 0);

    repeat (2) @(posedge clk_in);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_dmem_arbiter.md
# imem_dmem_arbiter

Shares a single-port unified memory between the core's instruction-fetch port and its load/store port. Arbitrates between the two requesters, sequences one memory transaction at a time over a req/gnt/rvalid bus, and returns read data and a one-cycle acknowledge to the winning port. Sits between the RISC-V core's fetch/load-store interfaces and the memory, and drives the core's stall signal.

## Interface
Parameters:
- `ADDR_W`, default 32: address width on every port.
- `DATA_W`, default 32: data width; the mask width is `DATA_W/8`.
- `STARVE_LIM`, default 2, legal range 1..15: the number of consecutive data-port wins allowed while a fetch request is pending.

Ports (clock and reset first):
- `clk_in`, in, 1: the single clock.
- `rst_in`, in, 1: asynchronous, active-low reset.
- `if_req_in`, in, 1: fetch request. Held high, with the address stable, until `if_ack_out`.
- `if_addr_in`, in, ADDR_W: fetch address.
- `if_rdata_out`, out, DATA_W: fetched instruction. Valid while `if_ack_out`=1 and held until the next fetch completes.
- `if_ack_out`, out, 1: one-cycle completion pulse for the fetch port.
- `dm_req_in`, in, 1: data request. Held high, with all fields stable, until `dm_ack_out`.
- `dm_we_in`, in, 1: 1 = store, 0 = load.
- `dm_addr_in`, in, ADDR_W: data address.
- `dm_wdata_in`, in, DATA_W: store data.
- `dm_mask_in`, in, DATA_W/8: byte-lane write mask.
- `dm_rdata_out`, out, DATA_W: load data. Updated only by loads.
- `dm_ack_out`, out, 1: one-cycle completion pulse for the data port.
- `mem_req_out`, mem_we_out, mem_addr_out, mem_wdata_out, mem_mask_out: out. Memory command. All fields are registered and stable while `mem_req_out`=1.
- `mem_gnt_in`, in, 1: memory accepted the command in this cycle.
- `mem_rvalid_in`, in, 1: response for the outstanding command. Memory returns a response for both reads and writes.
- `mem_rdata_in`, in, DATA_W: read data, valid with `mem_rvalid_in`.
- `stall_out`, out, 1: combinational. Equals `(if_req_in & ~if_ack_out) | (dm_req_in & ~dm_ack_out)`.
- `proto_err_out`, out, 1: sticky flag for a protocol violation.

## Operation
The FSM has four states: IDLE, REQ, WAIT, RESP. Exactly one transaction is outstanding at a time.

- **IDLE.** When any request is pending, select an owner and latch its command into the `mem_*` registers, then go to REQ.
  - If no request is pending, stay in IDLE.
- **REQ.** `mem_req_out`=1.
  - When `mem_gnt_in`=1, go to WAIT. `mem_req_out` drops in the next cycle.
  - Otherwise hold in REQ indefinitely. There is no timeout.
- **WAIT.** When `mem_rvalid_in`=1, go to RESP.
  - For a read, capture `mem_rdata_in` into the owner's rdata register.
- **RESP.** Pulse the owner's ack for exactly one cycle, then go to IDLE.
  - No arbitration takes place in RESP. The acked requester's still-high `req` in this cycle is therefore never re-served.

Arbitration (evaluated in IDLE only):
- Only one request pending: that port wins.
- Both pending: the data port wins unless `starve_cnt` == STARVE_LIM, in which case the fetch port wins.
- `starve_cnt` increments when the data port wins while `if_req_in`=1.
- `starve_cnt` clears when the fetch port wins.
- `starve_cnt` saturates at STARVE_LIM.

Errors:
- `mem_rvalid_in`=1 in IDLE, REQ or RESP sets `proto_err_out`. The response is otherwise ignored.
- `mem_gnt_in` outside REQ is ignored.
- `proto_err_out` is cleared only by reset.

Requester misbehaviour:
- If a requester drops `req` before its ack, the latched transaction still completes and the ack still pulses.

## Timing
- Reset (asynchronous, `rst_in`=0) puts the block in:
  - state IDLE;
  - `starve_cnt`=0;
  - every output 0, including rdata, ack, `mem_*` and `proto_err_out`.
- A reset mid-transaction abandons the transaction. The memory is reset on the same `rst_in`.
- Minimum latency, with gnt in the first REQ cycle and rvalid in the first WAIT cycle:
  - req sampled in IDLE at cycle 0;
  - `mem_req_out`=1 at cycle 1;
  - WAIT at cycle 2;
  - ack at cycle 3.
- Each extra gnt or rvalid wait cycle adds one cycle of latency.
- Back-to-back throughput: at best one transaction every 4 cycles.
- `mem_rvalid_in` is legal no earlier than the cycle after the gnt.
- A req that rises in RESP is arbitrated in the following IDLE cycle.

## Structure
- Shared package `riscv_pkg` holds:
  - `arb_state_t` {IDLE, REQ, WAIT, RESP};
  - owner constants `OWNER_IF`=1'b0 and `OWNER_DM`=1'b1.
- One sub-module, `arb_prio_sel`: the winner select plus the `starve_cnt` register, with its increment, clear and saturation.
- The top level holds the FSM, the command registers, the rdata and ack registers, the error flag and `stall_out`.

## Test plan
- **Single load.** Stimulus: `dm_req_in`=1, `dm_we_in`=0, addr 0x100; gnt at cycle 1; rvalid with data 0xDEADBEEF at cycle 2. Required response: `dm_ack_out` at cycle 3 with `dm_rdata_out`=0xDEADBEEF; `stall_out`=1 for cycles 0–2.
- **Store.** Stimulus: addr 0x204, data 0x12345678, mask 4'b0011; gnt held low for 3 REQ cycles. Required response: `mem_*` stable for those 3 cycles, then ack 2 cycles after the gnt; `dm_rdata_out` unchanged.
- **Starvation (STARVE_LIM=2).** Stimulus: both ports request continuously. Required response: grant order DM, DM, IF, DM, DM, IF.
- **Protocol error.** Stimulus: rvalid in IDLE. Required response: `proto_err_out`=1 and stays 1; no ack; the next normal transaction completes correctly.
- **Reset mid-WAIT.** Stimulus: `rst_in`=0 for 1 cycle while in WAIT. Required response: all outputs 0 immediately; the next fetch at 0x0 completes with minimum latency.
- **Ack-cycle request.** Stimulus: fetch acked in RESP while `if_req_in` stays high for a new address 0x4 and `dm_req_in` is also high. Required response: the data port wins in the following IDLE (`starve_cnt` was cleared); the fetch at 0x4 is served next.
